// File: rtl/fwd_lookup_ctrl.sv
// fwd_lookup_ctrl: requester side of the MAC address table.
// Accepts one header at a time (hdr_*), issues learn/lookup requests (tbl_*),
// waits LOOKUP_LATENCY cycles, presents a forwarding decision (fwd_*), and
// keeps saturating per-class delivery counters (cnt_*).
module fwd_lookup_ctrl #(
  parameter int NUM_PORTS      = 4,
  parameter int LOOKUP_LATENCY = 1,
  parameter int CNT_W          = 16,
  localparam int PW            = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hdr_valid_i,
  output logic                 hdr_ready_o,
  input  logic [47:0]          hdr_dst_i,
  input  logic [47:0]          hdr_src_i,
  input  logic [PW-1:0]        hdr_port_i,
  output logic                 tbl_learn_req_o,
  output logic [47:0]          tbl_learn_address_o,
  output logic [PW-1:0]        tbl_learn_port_o,
  output logic                 tbl_read_req_o,
  output logic [47:0]          tbl_read_address_o,
  input  logic [PW-1:0]        tbl_read_port_i,
  input  logic                 tbl_read_valid_i,
  output logic                 fwd_valid_o,
  input  logic                 fwd_ready_i,
  output logic [NUM_PORTS-1:0] fwd_mask_o,
  output logic                 fwd_drop_o,
  output logic [CNT_W-1:0]     cnt_unicast_o,
  output logic [CNT_W-1:0]     cnt_flood_o,
  output logic [CNT_W-1:0]     cnt_drop_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
  typedef enum logic [1:0] {CLS_UNICAST, CLS_FLOOD, CLS_DROP} class_e;

  localparam logic [2:0] WAIT_INIT = 3'(LOOKUP_LATENCY - 1);

  state_e               state_q, state_d;
  class_e               class_q, class_d;
  logic                 hdr_ready_q, hdr_ready_d;
  logic [47:0]          dst_q, dst_d;
  logic [47:0]          src_q, src_d;
  logic [PW-1:0]        port_q, port_d;
  logic                 learn_req_q, learn_req_d;
  logic                 read_req_q, read_req_d;
  logic [2:0]           wait_q, wait_d;
  logic [NUM_PORTS-1:0] mask_q, mask_d;
  logic                 drop_q, drop_d;
  logic [CNT_W-1:0]     cnt_uni_q, cnt_uni_d;
  logic [CNT_W-1:0]     cnt_flood_q, cnt_flood_d;
  logic [CNT_W-1:0]     cnt_drop_q, cnt_drop_d;

  logic                 hdr_accept;
  logic                 tbl_hit;
  logic [NUM_PORTS-1:0] flood_mask;
  logic [NUM_PORTS-1:0] uni_mask;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign hdr_accept = hdr_valid_i & hdr_ready_q;
  // Out-of-range result ports count as a miss.
  assign tbl_hit    = tbl_read_valid_i && (32'(tbl_read_port_i) < 32'(NUM_PORTS));

  always_comb begin
    flood_mask         = '1;
    flood_mask[port_q] = 1'b0;
    uni_mask           = '0;
    uni_mask[tbl_read_port_i] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    class_d     = class_q;
    dst_d       = dst_q;
    src_d       = src_q;
    port_d      = port_q;
    learn_req_d = 1'b0;
    read_req_d  = 1'b0;
    wait_d      = wait_q;
    mask_d      = mask_q;
    drop_d      = drop_q;
    cnt_uni_d   = cnt_uni_q;
    cnt_flood_d = cnt_flood_q;
    cnt_drop_d  = cnt_drop_q;

    unique case (state_q)
      IDLE: begin
        if (hdr_accept) begin
          dst_d       = hdr_dst_i;
          src_d       = hdr_src_i;
          port_d      = hdr_port_i;
          // Requests are computed from the inputs here so the registered
          // pulses line up with the REQ cycle.
          learn_req_d = ~hdr_src_i[40] & (hdr_src_i != '0);
          read_req_d  = ~hdr_dst_i[40];
          state_d     = REQ;
        end
      end
      REQ: begin
        if (dst_q[40]) begin
          mask_d  = flood_mask;
          drop_d  = 1'b0;
          class_d = CLS_FLOOD;
          state_d = RESP;
        end else begin
          wait_d  = WAIT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_q == '0) begin
          if (!tbl_hit) begin
            mask_d  = flood_mask;
            drop_d  = 1'b0;
            class_d = CLS_FLOOD;
          end else if (tbl_read_port_i == port_q) begin
            mask_d  = '0;
            drop_d  = 1'b1;
            class_d = CLS_DROP;
          end else begin
            mask_d  = uni_mask;
            drop_d  = 1'b0;
            class_d = CLS_UNICAST;
          end
          state_d = RESP;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      RESP: begin
        if (fwd_ready_i) begin
          unique case (class_q)
            CLS_UNICAST: cnt_uni_d   = sat_inc(cnt_uni_q);
            CLS_FLOOD:   cnt_flood_d = sat_inc(cnt_flood_q);
            default:     cnt_drop_d  = sat_inc(cnt_drop_q);
          endcase
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    hdr_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      class_q     <= CLS_UNICAST;
      hdr_ready_q <= 1'b0;
      dst_q       <= '0;
      src_q       <= '0;
      port_q      <= '0;
      learn_req_q <= 1'b0;
      read_req_q  <= 1'b0;
      wait_q      <= '0;
      mask_q      <= '0;
      drop_q      <= 1'b0;
      cnt_uni_q   <= '0;
      cnt_flood_q <= '0;
      cnt_drop_q  <= '0;
    end else begin
      state_q     <= state_d;
      class_q     <= class_d;
      hdr_ready_q <= hdr_ready_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      port_q      <= port_d;
      learn_req_q <= learn_req_d;
      read_req_q  <= read_req_d;
      wait_q      <= wait_d;
      mask_q      <= mask_d;
      drop_q      <= drop_d;
      cnt_uni_q   <= cnt_uni_d;
      cnt_flood_q <= cnt_flood_d;
      cnt_drop_q  <= cnt_drop_d;
    end
  end

  assign hdr_ready_o         = hdr_ready_q;
  assign tbl_learn_req_o     = learn_req_q;
  assign tbl_learn_address_o = src_q;
  assign tbl_learn_port_o    = port_q;
  assign tbl_read_req_o      = read_req_q;
  assign tbl_read_address_o  = dst_q;
  assign fwd_valid_o         = (state_q == RESP);
  assign fwd_mask_o          = mask_q;
  assign fwd_drop_o          = drop_q;
  assign cnt_unicast_o       = cnt_uni_q;
  assign cnt_flood_o         = cnt_flood_q;
  assign cnt_drop_o          = cnt_drop_q;

endmodule

// File: tb/tb_fwd_lookup_ctrl.sv
module tb_fwd_lookup_ctrl;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1, rst_b = 1'b1;
  logic        hdr_valid = 1'b0;
  logic [47:0] hdr_dst = '0, hdr_src = '0;
  logic [1:0]  hdr_port = '0;
  logic [1:0]  tbl_port = '0;
  logic        tbl_valid = 1'b0;
  logic        fwd_ready = 1'b0;

  logic        a_hdr_ready, a_learn_req, a_read_req, a_fwd_valid, a_drop;
  logic [47:0] a_learn_addr, a_read_addr;
  logic [1:0]  a_learn_port;
  logic [3:0]  a_mask;
  logic [15:0] a_cnt_uni, a_cnt_flood, a_cnt_drop;

  logic        b_hdr_ready, b_learn_req, b_read_req, b_fwd_valid, b_drop;
  logic [47:0] b_learn_addr, b_read_addr;
  logic [1:0]  b_learn_port;
  logic [3:0]  b_mask;
  logic [1:0]  b_cnt_uni, b_cnt_flood, b_cnt_drop;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_lookup_ctrl #(.NUM_PORTS(4), .LOOKUP_LATENCY(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst_a),
    .hdr_valid_i(hdr_valid), .hdr_ready_o(a_hdr_ready),
    .hdr_dst_i(hdr_dst), .hdr_src_i(hdr_src), .hdr_port_i(hdr_port),
    .tbl_learn_req_o(a_learn_req), .tbl_learn_address_o(a_learn_addr),
    .tbl_learn_port_o(a_learn_port), .tbl_read_req_o(a_read_req),
    .tbl_read_address_o(a_read_addr), .tbl_read_port_i(tbl_port),
    .tbl_read_valid_i(tbl_valid),
    .fwd_valid_o(a_fwd_valid), .fwd_ready_i(fwd_ready),
    .fwd_mask_o(a_mask), .fwd_drop_o(a_drop),
    .cnt_unicast_o(a_cnt_uni), .cnt_flood_o(a_cnt_flood), .cnt_drop_o(a_cnt_drop)
  );

  fwd_lookup_ctrl #(.NUM_PORTS(4), .LOOKUP_LATENCY(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst_b),
    .hdr_valid_i(hdr_valid), .hdr_ready_o(b_hdr_ready),
    .hdr_dst_i(hdr_dst), .hdr_src_i(hdr_src), .hdr_port_i(hdr_port),
    .tbl_learn_req_o(b_learn_req), .tbl_learn_address_o(b_learn_addr),
    .tbl_learn_port_o(b_learn_port), .tbl_read_req_o(b_read_req),
    .tbl_read_address_o(b_read_addr), .tbl_read_port_i(tbl_port),
    .tbl_read_valid_i(tbl_valid),
    .fwd_valid_o(b_fwd_valid), .fwd_ready_i(fwd_ready),
    .fwd_mask_o(b_mask), .fwd_drop_o(b_drop),
    .cnt_unicast_o(b_cnt_uni), .cnt_flood_o(b_cnt_flood), .cnt_drop_o(b_cnt_drop)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a header and returns in the cycle after the accepting edge.
  task automatic accept(input bit on_b, input logic [47:0] dst, input logic [47:0] src,
                        input logic [1:0] port);
    logic rdy;
    hdr_dst = dst; hdr_src = src; hdr_port = port; hdr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rdy = on_b ? b_hdr_ready : a_hdr_ready;
      if (rdy) break;
      step();
    end
    rdy = on_b ? b_hdr_ready : a_hdr_ready;
    checks++;
    if (rdy !== 1'b1) begin
      errors++; $display("FAIL accept_wait: hdr_ready=%b required 1", rdy);
    end
    step();
    hdr_valid = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    checks++;
    if ({a_hdr_ready, a_learn_req, a_read_req, a_fwd_valid, a_drop, a_mask} !== 9'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b required 0",
                         {a_hdr_ready, a_learn_req, a_read_req, a_fwd_valid, a_drop, a_mask});
    end
    checks++;
    if ({a_cnt_uni, a_cnt_flood, a_cnt_drop} !== 48'h0) begin
      errors++; $display("FAIL reset_cnt: got %h required 0", {a_cnt_uni, a_cnt_flood, a_cnt_drop});
    end
    rst_a = 1'b0;
    #1;
    checks++;
    if (a_hdr_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_early: got %b required 0", a_hdr_ready);
    end
    step();
    checks++;
    if (a_hdr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b required 1", a_hdr_ready);
    end
  endtask

  task automatic test_unicast();
    tbl_valid = 1'b1; tbl_port = 2'd1; fwd_ready = 1'b1;
    accept(1'b0, 48'h001122334455, 48'h00AA00000001, 2'd2);
    checks++;
    if ({a_learn_req, a_read_req, a_learn_port, a_hdr_ready, a_fwd_valid} !== 6'b11_10_00) begin
      errors++; $display("FAIL uni_req: got %b required 111000",
                         {a_learn_req, a_read_req, a_learn_port, a_hdr_ready, a_fwd_valid});
    end
    checks++;
    if (a_learn_addr !== 48'h00AA00000001 || a_read_addr !== 48'h001122334455) begin
      errors++; $display("FAIL uni_addr: learn=%h read=%h required 00aa00000001/001122334455",
                         a_learn_addr, a_read_addr);
    end
    step();
    checks++;
    if ({a_learn_req, a_read_req, a_fwd_valid} !== 3'b000) begin
      errors++; $display("FAIL uni_wait: got %b required 000", {a_learn_req, a_read_req, a_fwd_valid});
    end
    step();
    checks++;
    if ({a_fwd_valid, a_mask, a_drop} !== 6'b1_0010_0) begin
      errors++; $display("FAIL uni_decision: got %b required 1_0010_0", {a_fwd_valid, a_mask, a_drop});
    end
    step();
    checks++;
    if (a_cnt_uni !== 16'd1 || a_fwd_valid !== 1'b0 || a_hdr_ready !== 1'b1) begin
      errors++; $display("FAIL uni_count: cnt=%0d valid=%b ready=%b required 1/0/1",
                         a_cnt_uni, a_fwd_valid, a_hdr_ready);
    end
  endtask

  task automatic test_miss();
    tbl_valid = 1'b0; tbl_port = 2'd1;
    accept(1'b0, 48'h001122334455, 48'h00AA00000001, 2'd0);
    step();
    checks++;
    if (a_fwd_valid !== 1'b0) begin
      errors++; $display("FAIL miss_early: valid=%b required 0", a_fwd_valid);
    end
    step();
    checks++;
    if ({a_fwd_valid, a_mask, a_drop} !== 6'b1_1110_0) begin
      errors++; $display("FAIL miss_decision: got %b required 1_1110_0", {a_fwd_valid, a_mask, a_drop});
    end
    step();
    checks++;
    if (a_cnt_flood !== 16'd1 || a_cnt_uni !== 16'd1) begin
      errors++; $display("FAIL miss_count: flood=%0d uni=%0d required 1/1", a_cnt_flood, a_cnt_uni);
    end
  endtask

  task automatic test_broadcast();
    tbl_valid = 1'b1; tbl_port = 2'd1;
    accept(1'b0, 48'hFFFFFFFFFFFF, 48'h00AA00000001, 2'd3);
    checks++;
    if ({a_learn_req, a_read_req, a_fwd_valid} !== 3'b100) begin
      errors++; $display("FAIL bcast_req: got %b required 100", {a_learn_req, a_read_req, a_fwd_valid});
    end
    step();
    checks++;
    if ({a_fwd_valid, a_mask, a_drop, a_read_req} !== 7'b1_0111_0_0) begin
      errors++; $display("FAIL bcast_decision: got %b required 1_0111_0_0",
                         {a_fwd_valid, a_mask, a_drop, a_read_req});
    end
    step();
    checks++;
    if (a_cnt_flood !== 16'd2) begin
      errors++; $display("FAIL bcast_count: flood=%0d required 2", a_cnt_flood);
    end
  endtask

  task automatic test_hairpin();
    tbl_valid = 1'b1; tbl_port = 2'd2;
    accept(1'b0, 48'h001122334455, 48'h00AA00000001, 2'd2);
    step(); step();
    checks++;
    if ({a_fwd_valid, a_mask, a_drop} !== 6'b1_0000_1) begin
      errors++; $display("FAIL hairpin_decision: got %b required 1_0000_1", {a_fwd_valid, a_mask, a_drop});
    end
    step();
    checks++;
    if (a_cnt_drop !== 16'd1) begin
      errors++; $display("FAIL hairpin_count: drop=%0d required 1", a_cnt_drop);
    end
  endtask

  task automatic test_back_to_back();
    fwd_ready = 1'b0; tbl_valid = 1'b1; tbl_port = 2'd3;
    accept(1'b0, 48'h001122334455, 48'h01005E000001, 2'd1);
    hdr_valid = 1'b1; hdr_dst = 48'h000000000077; hdr_src = 48'h00BB00000002; hdr_port = 2'd0;
    checks++;
    if ({a_learn_req, a_read_req} !== 2'b01) begin
      errors++; $display("FAIL bp_req: got %b required 01", {a_learn_req, a_read_req});
    end
    step(); step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({a_fwd_valid, a_mask, a_drop, a_hdr_ready, a_learn_req} !== 8'b1_1000_0_0_0) begin
        errors++; $display("FAIL bp_hold[%0d]: got %b required 1_1000_0_0_0", i,
                           {a_fwd_valid, a_mask, a_drop, a_hdr_ready, a_learn_req});
      end
      step();
    end
    fwd_ready = 1'b1;
    step();
    checks++;
    if (a_hdr_ready !== 1'b1 || a_fwd_valid !== 1'b0 || a_cnt_uni !== 16'd2) begin
      errors++; $display("FAIL bp_release: ready=%b valid=%b uni=%0d required 1/0/2",
                         a_hdr_ready, a_fwd_valid, a_cnt_uni);
    end
    step();
    hdr_valid = 1'b0;
    checks++;
    if ({a_learn_req, a_read_req, a_learn_port} !== 4'b11_00 || a_learn_addr !== 48'h00BB00000002) begin
      errors++; $display("FAIL bp_second_req: req/port=%b addr=%h required 1100/00bb00000002",
                         {a_learn_req, a_read_req, a_learn_port}, a_learn_addr);
    end
    step(); step();
    checks++;
    if ({a_fwd_valid, a_mask, a_drop} !== 6'b1_1000_0) begin
      errors++; $display("FAIL bp_second_decision: got %b required 1_1000_0", {a_fwd_valid, a_mask, a_drop});
    end
    step();
    checks++;
    if (a_cnt_uni !== 16'd3) begin
      errors++; $display("FAIL bp_second_count: uni=%0d required 3", a_cnt_uni);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic seen;
    rst_a = 1'b1;
    rst_b = 1'b0;
    step();
    checks++;
    if (b_hdr_ready !== 1'b1) begin
      errors++; $display("FAIL rw_ready: got %b required 1", b_hdr_ready);
    end
    fwd_ready = 1'b1; tbl_valid = 1'b1; tbl_port = 2'd1;
    accept(1'b1, 48'h001122334455, 48'h00AA00000001, 2'd2);
    checks++;
    if (b_read_req !== 1'b1) begin
      errors++; $display("FAIL rw_read_req: got %b required 1", b_read_req);
    end
    step();
    #1 rst_b = 1'b1;
    #1;
    checks++;
    if ({b_hdr_ready, b_learn_req, b_read_req, b_fwd_valid, b_drop, b_mask,
         b_cnt_uni, b_cnt_flood, b_cnt_drop} !== 15'b0) begin
      errors++; $display("FAIL rw_async_clear: got %b required 0",
                         {b_hdr_ready, b_learn_req, b_read_req, b_fwd_valid, b_drop, b_mask,
                          b_cnt_uni, b_cnt_flood, b_cnt_drop});
    end
    checks++;
    if ({b_learn_addr, b_read_addr, b_learn_port} !== 98'b0) begin
      errors++; $display("FAIL rw_addr_clear: learn=%h read=%h port=%0d required 0",
                         b_learn_addr, b_read_addr, b_learn_port);
    end
    step();
    rst_b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen = seen | b_fwd_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rw_no_decision: fwd_valid seen=%b required 0", seen);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5];
    int n;
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    fwd_ready = 1'b1; tbl_valid = 1'b1; tbl_port = 2'd2;
    for (int i = 0; i < 5; i++) begin
      accept(1'b1, 48'h001122334455, 48'h00AA00000001, 2'd2);
      n = 1;
      while (!b_fwd_valid && n < 20) begin
        step();
        n++;
      end
      checks++;
      if (n !== 6 || {b_mask, b_drop} !== 5'b0000_1) begin
        errors++; $display("FAIL sat_latency[%0d]: cycles=%0d mask/drop=%b required 6/0000_1",
                           i, n, {b_mask, b_drop});
      end
      step();
      checks++;
      if (b_cnt_drop !== exp_cnt[i]) begin
        errors++; $display("FAIL sat_count[%0d]: drop=%0d required %0d", i, b_cnt_drop, exp_cnt[i]);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unicast();
    test_miss();
    test_broadcast();
    test_hairpin();
    test_back_to_back();
    test_reset_mid_wait();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
